prep_busy_scheduler: RTL and testbench

PREP_BUSY_SCHEDULER -- requirements
Module: prep_busy_scheduler

---
 rtl/prep_pkg.sv | 29 ++
 rtl/prep_poll_table.sv | 27 ++
 rtl/prep_busy_scheduler.sv | 168 ++++++++++++++++
 tb/tb_prep_busy_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prep_pkg.sv
`default_nettype none
// ============================================================================
// prep_pkg : shared states, register numbers, op codes and poll-count tables
// Rev 1.0
// ============================================================================
package prep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] REG_PREP   = 8'h26;
    localparam logic [7:0] REG_STATUS = 8'h27;
    localparam logic [7:0] PREP_START = 8'h01;
    localparam logic [7:0] OP_09      = 8'h09;
    localparam logic [7:0] OP_03      = 8'h03;

    // Index 0 is the leftmost entry: poll counts per completed prepare cycle.
    localparam logic [0:7][7:0] POLL_TBL_09 = {
        8'd13, 8'd14, 8'd5, 8'd13, 8'd13, 8'd14, 8'd14, 8'd14
    };
    localparam logic [0:7][7:0] POLL_TBL_03 = {
        8'd10, 8'd10, 8'd9, 8'd10, 8'd10, 8'd4, 8'd35, 8'd36
    };

endpackage
`default_nettype wire

// File: rtl/prep_poll_table.sv
`default_nettype none
// ============================================================================
// prep_poll_table : combinational poll-count lookup by op code and index
// Rev 1.0
// ============================================================================
module prep_poll_table
    import prep_pkg::*;
(
    input  logic [7:0] op_i,
    input  logic [3:0] idx_i,
    output logic [7:0] count_o
);

    logic [2:0] idx_c;

    always_comb begin
        idx_c   = (idx_i > 4'd7) ? 3'd7 : idx_i[2:0];
        count_o = 8'd0;
        if (op_i == OP_09) begin
            count_o = POLL_TBL_09[idx_c];
        end else if (op_i == OP_03) begin
            count_o = POLL_TBL_03[idx_c];
        end
    end

endmodule
`default_nettype wire

// File: rtl/prep_busy_scheduler.sv
`default_nettype none
// ============================================================================
// prep_busy_scheduler : prepare-cycle counter and register 0x27 busy poller
// Optional busy timeout enabled by defining PREP_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module prep_busy_scheduler
    import prep_pkg::*;
#(
    parameter int CNT_MAX     = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk_20mhz,
    input  logic       reset,
    input  logic       wr_stb,
    input  logic       rd_stb,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic [3:0] prep_cnt,
    output logic       serial_ready,
    output logic       phase_err,
    output logic       timeout
);

    localparam logic [3:0] CNT_SAT = 4'(CNT_MAX);

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] remain_q, remain_d;
    logic [3:0] prep_cnt_q, prep_cnt_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       phase_err_q, phase_err_d;

    logic       rd_status_w;
    logic       wr_status_w;
    logic       wr_prep_w;
    logic [3:0] tbl_idx_w;
    logic [7:0] tbl_cnt_w;

    assign rd_status_w = rd_stb && (reg_addr == REG_STATUS);
    assign wr_status_w = wr_stb && (reg_addr == REG_STATUS);
    assign wr_prep_w   = wr_stb && (reg_addr == REG_PREP);
    assign tbl_idx_w   = (prep_cnt_q == 4'd0) ? 4'd0 : prep_cnt_q - 4'd1;

    prep_poll_table u_poll_table (
        .op_i    (wr_data),
        .idx_i   (tbl_idx_w),
        .count_o (tbl_cnt_w)
    );

`ifdef PREP_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
`else
    logic unused_tmo_w;
    assign unused_tmo_w = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remain_d    = remain_q;
        prep_cnt_d  = prep_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        phase_err_d = phase_err_q;
`ifdef PREP_TIMEOUT_EN
        timeout_d   = timeout_q;
        tmo_cnt_d   = 16'd0;
        if (state_q == ST_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_d = 16'd0;
                timeout_d = 1'b1;
                state_d   = ST_DONE;
            end
        end
        if (rd_status_w || wr_status_w) begin
            tmo_cnt_d = 16'd0;
        end
`endif

        // Read is answered from the pre-write state; a same-cycle write overrides below.
        if (rd_status_w) begin
            rd_valid_d = 1'b1;
            rd_data_d  = 8'h00;
            case (state_q)
                ST_BUSY: begin
                    if (remain_q > 8'd1) begin
                        rd_data_d = op_q;
                        remain_d  = remain_q - 8'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: ;
            endcase
        end

        if (wr_status_w) begin
            op_d = wr_data;
            if ((wr_data == OP_09) || (wr_data == OP_03)) begin
                remain_d = tbl_cnt_w;
                state_d  = ST_BUSY;
                if (prep_cnt_q == 4'd0) begin
                    phase_err_d = 1'b1;
                end
            end else begin
                remain_d = 8'd0;
                state_d  = ST_DONE;
            end
        end

        if (wr_prep_w && (wr_data == PREP_START) && (prep_cnt_q < CNT_SAT)) begin
            prep_cnt_d = prep_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 8'h00;
            remain_q    <= 8'd0;
            prep_cnt_q  <= 4'd0;
            rd_data_q   <= 8'hFF;
            rd_valid_q  <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remain_q    <= remain_d;
            prep_cnt_q  <= prep_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            phase_err_q <= phase_err_d;
        end
    end

`ifdef PREP_TIMEOUT_EN
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            tmo_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign busy         = (state_q == ST_BUSY);
    assign prep_cnt     = prep_cnt_q;
    assign serial_ready = (prep_cnt_q >= 4'd7);
    assign phase_err    = phase_err_q;

endmodule
`default_nettype wire

// File: tb/tb_prep_busy_scheduler.sv
`default_nettype none
// ============================================================================
// tb_prep_busy_scheduler : directed stimulus with a queue-based read scoreboard
// Rev 1.0
// ============================================================================
module tb_prep_busy_scheduler;

    logic       clk;
    logic       reset;
    logic       wr_stb;
    logic       rd_stb;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic [3:0] prep_cnt;
    logic       serial_ready;
    logic       phase_err;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    prep_busy_scheduler #(
        .CNT_MAX     (8),
        .TIMEOUT_CYC (20000)
    ) dut (
        .clk_20mhz    (clk),
        .reset        (reset),
        .wr_stb       (wr_stb),
        .rd_stb       (rd_stb),
        .reg_addr     (reg_addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .prep_cnt     (prep_cnt),
        .serial_ready (serial_ready),
        .phase_err    (phase_err),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid actual=1 required=0 rd_data=%0h", rd_data);
            end else begin
                chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_stb   = 1'b1;
        reg_addr = a;
        wr_data  = d;
        @(negedge clk);
        wr_stb   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp);
        @(negedge clk);
        rd_stb   = 1'b1;
        reg_addr = 8'h27;
        exp_q.push_back(exp);
        @(negedge clk);
        rd_stb   = 1'b0;
    endtask

    task automatic rd_seq(input int n, input logic [7:0] op);
        for (int i = 0; i < n; i++) rd(op);
        rd(8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_stb = 1'b0; rd_stb = 1'b0; reg_addr = 8'h00; wr_data = 8'h00;
        do_reset();
        chk("rst_rd_data", {24'd0, rd_data}, 32'hFF);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_prep_cnt", {28'd0, prep_cnt}, 32'd0);
        chk("rst_serial_ready", {31'd0, serial_ready}, 32'd0);
        chk("rst_phase_err", {31'd0, phase_err}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);

        wr(8'h26, 8'h01);
        chk("cnt_after_one", {28'd0, prep_cnt}, 32'd1);
        wr(8'h30, 8'h55);
        chk("ignored_wr_busy", {31'd0, busy}, 32'd0);
        wr(8'h27, 8'h09);
        chk("busy_after_09", {31'd0, busy}, 32'd1);
        chk("no_phase_err", {31'd0, phase_err}, 32'd0);
        for (int i = 0; i < 12; i++) rd(8'h09);
        chk("busy_before_last", {31'd0, busy}, 32'd1);
        rd(8'h00);
        chk("busy_fall_13th", {31'd0, busy}, 32'd0);
        rd(8'h00);
        rd(8'h00);

        @(negedge clk);
        rd_stb = 1'b1; reg_addr = 8'h26;
        @(negedge clk);
        rd_stb = 1'b0;
        chk("other_addr_no_valid", {31'd0, rd_valid}, 32'd0);

        for (int i = 0; i < 6; i++) wr(8'h26, 8'h01);
        chk("cnt_seven", {28'd0, prep_cnt}, 32'd7);
        chk("serial_ready", {31'd0, serial_ready}, 32'd1);
        wr(8'h26, 8'h05);
        chk("cnt_non01_hold", {28'd0, prep_cnt}, 32'd7);
        // Index 6 of the 0x03 table loads 35: 34 op reads, then 0x00.
        wr(8'h27, 8'h03);
        rd_seq(34, 8'h03);
        chk("busy_after_03", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 3; i++) wr(8'h26, 8'h01);
        chk("cnt_saturate", {28'd0, prep_cnt}, 32'd8);
        wr(8'h27, 8'h09);
        for (int i = 0; i < 9; i++) rd(8'h09);
        @(negedge clk);
        rd_stb = 1'b1; wr_stb = 1'b1; reg_addr = 8'h27; wr_data = 8'h03;
        exp_q.push_back(8'h09);
        @(negedge clk);
        rd_stb = 1'b0; wr_stb = 1'b0;
        chk("reload_wins_busy", {31'd0, busy}, 32'd1);
        rd_seq(35, 8'h03);
        chk("busy_after_36", {31'd0, busy}, 32'd0);

        wr(8'h27, 8'h05);
        chk("other_op_not_busy", {31'd0, busy}, 32'd0);
        rd(8'h00);
        rd(8'h00);

        do_reset();
        wr(8'h27, 8'h09);
        chk("phase_err_set", {31'd0, phase_err}, 32'd1);
        rd_seq(12, 8'h09);
        chk("phase_busy_fall", {31'd0, busy}, 32'd0);

        wr(8'h27, 8'h09);
        @(negedge clk);
        rd_stb = 1'b1; reg_addr = 8'h27; reset = 1'b1;
        @(negedge clk);
        rd_stb = 1'b0; reset = 1'b0;
        chk("mid_reset_no_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_rd_data", {24'd0, rd_data}, 32'hFF);
        chk("mid_reset_phase_err", {31'd0, phase_err}, 32'd0);

        wr(8'h26, 8'h01);
        wr(8'h27, 8'h09);
`ifdef PREP_TIMEOUT_EN
        repeat (20005) @(negedge clk);
        chk("timeout_set", {31'd0, timeout}, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        rd(8'h00);
`else
        repeat (100) @(negedge clk);
        chk("timeout_tied", {31'd0, timeout}, 32'd0);
        chk("still_busy", {31'd0, busy}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
